// File: rtl/screen_buffer_ctrl_if.sv
// Command port of the screen buffer: CPU-side valid/ready commands plus the LOAD result.
interface screen_buffer_ctrl_if #(
  parameter int XW = 5,
  parameter int YW = 5
);
  logic          I_cmd_valid;
  logic          O_cmd_ready;
  logic [2:0]    I_cmd;
  logic [XW-1:0] I_x;
  logic [YW-1:0] I_y;
  logic          O_pixel;
  logic          O_pixel_valid;

  modport master (
    output I_cmd_valid, I_cmd, I_x, I_y,
    input  O_cmd_ready, O_pixel, O_pixel_valid
  );

  modport slave (
    input  I_cmd_valid, I_cmd, I_x, I_y,
    output O_cmd_ready, O_pixel, O_pixel_valid
  );
endinterface

// File: rtl/screen_buffer_ctrl.sv
// Double-buffered 1-bpp frame store: CPU edits the back buffer, PUSH copies it to the
// front buffer one row per clock (optionally gated by vsync), video reads the front buffer.
module screen_buffer_ctrl #(
  parameter int W             = 32,
  parameter int H             = 32,
  parameter int XW            = 5,
  parameter int YW            = 5,
  parameter bit PUSH_ON_VSYNC = 1'b1
) (
  input  logic                I_clk,
  input  logic                I_rst,
  screen_buffer_ctrl_if.slave cmd_if,
  input  logic                I_vsync,
  input  logic [XW-1:0]       I_rd_x,
  input  logic [YW-1:0]       I_rd_y,
  output logic                O_rd_pixel,
  output logic                O_busy
);

  localparam int RW = (H > 1) ? $clog2(H) : 1;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [YW-1:0] LAST_ROW = YW'(H - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_VS, ST_COPY, ST_CLEAR} state_t;
  typedef enum logic [2:0] {
    CMD_NOP    = 3'd0,
    CMD_DRAW   = 3'd1,
    CMD_CLEAR  = 3'd2,
    CMD_LOAD   = 3'd3,
    CMD_PUSH   = 3'd4,
    CMD_CLRSCR = 3'd5
  } cmd_t;

  state_t                 state_q, state_d;
  logic [YW-1:0]          row_q, row_d;
  logic [H-1:0][W-1:0]    back_q, back_d;
  logic [H-1:0][W-1:0]    front_q, front_d;
  logic                   pixel_q, pixel_d;
  logic                   pixel_valid_q, pixel_valid_d;
  logic                   rd_pixel_q, rd_pixel_d;
  logic                   accept;

  assign cmd_if.O_cmd_ready   = (state_q == ST_IDLE);
  assign cmd_if.O_pixel       = pixel_q;
  assign cmd_if.O_pixel_valid = pixel_valid_q;
  assign O_rd_pixel           = rd_pixel_q;
  assign O_busy               = (state_q != ST_IDLE);

  always_comb begin
    state_d       = state_q;
    row_d         = row_q;
    back_d        = back_q;
    front_d       = front_q;
    pixel_d       = pixel_q;
    pixel_valid_d = 1'b0;
    rd_pixel_d    = 1'b0;
    accept        = cmd_if.I_cmd_valid && (state_q == ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          // Address decode by exhaustive match: out-of-range x/y never match, so they
          // are ignored for DRAW/CLEAR and read as 0 for LOAD without aliasing.
          case (cmd_if.I_cmd)
            CMD_DRAW, CMD_CLEAR: begin
              for (int unsigned r = 0; r < H; r++)
                for (int unsigned c = 0; c < W; c++)
                  if (r == 32'(cmd_if.I_y) && c == 32'(cmd_if.I_x))
                    back_d[RW'(r)][CW'(c)] = (cmd_if.I_cmd == CMD_DRAW);
            end
            CMD_LOAD: begin
              pixel_valid_d = 1'b1;
              pixel_d       = 1'b0;
              for (int unsigned r = 0; r < H; r++)
                for (int unsigned c = 0; c < W; c++)
                  if (r == 32'(cmd_if.I_y) && c == 32'(cmd_if.I_x))
                    pixel_d = back_q[RW'(r)][CW'(c)];
            end
            CMD_PUSH: begin
              state_d = PUSH_ON_VSYNC ? ST_WAIT_VS : ST_COPY;
              row_d   = '0;
            end
            CMD_CLRSCR: begin
              state_d = ST_CLEAR;
              row_d   = '0;
            end
            default: ;
          endcase
        end
      end
      ST_WAIT_VS: begin
        if (I_vsync) state_d = ST_COPY;
      end
      ST_COPY, ST_CLEAR: begin
        for (int unsigned r = 0; r < H; r++) begin
          if (r == 32'(row_q)) begin
            if (state_q == ST_COPY) front_d[RW'(r)] = back_q[RW'(r)];
            else                    back_d[RW'(r)]  = '0;
          end
        end
        if (row_q == LAST_ROW) begin
          state_d = ST_IDLE;
          row_d   = '0;
        end else begin
          row_d = row_q + YW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    for (int unsigned r = 0; r < H; r++)
      for (int unsigned c = 0; c < W; c++)
        if (r == 32'(I_rd_y) && c == 32'(I_rd_x))
          rd_pixel_d = front_q[RW'(r)][CW'(c)];
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q       <= ST_IDLE;
      row_q         <= '0;
      back_q        <= '0;
      front_q       <= '0;
      pixel_q       <= 1'b0;
      pixel_valid_q <= 1'b0;
      rd_pixel_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      back_q        <= back_d;
      front_q       <= front_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
      rd_pixel_q    <= rd_pixel_d;
    end
  end

endmodule

// File: doc/screen_buffer_ctrl.md
Name: screen_buffer_ctrl

Overview:
Parametrised, double-buffered pixel frame store between the CPU display port and the HDMI scan-out.
- CPU side issues draw, clear, load, push and clear-screen commands through a valid/ready port. These act on the back buffer.
- Video side reads the front buffer through a registered read port.
- PUSH copies back to front, one row per clock, starting at the next video frame boundary, so the picture never tears.
- This replaces the fixed 32x32 screen buffer array and is generic in width, height and push mode.

Parameters:
W, 32, pixels per row (1..64)
H, 32, rows (1..64)
XW, 5, x coordinate width; must satisfy 2^XW >= W
YW, 5, y coordinate width; must satisfy 2^YW >= H
PUSH_ON_VSYNC, 1, 1 = copy waits for I_vsync; 0 = copy starts the cycle after PUSH is accepted

Ports:
I_clk  input  1  system clock
I_rst  input  1  reset, synchronous, active-high
I_cmd_valid  input  1  command present
O_cmd_ready  output  1  block can accept a command this cycle
I_cmd  input  3  0 NOP, 1 DRAW, 2 CLEAR, 3 LOAD, 4 PUSH, 5 CLRSCR, 6-7 treated as NOP
I_x  input  XW  pixel column
I_y  input  YW  pixel row
O_pixel  output  1  LOAD result
O_pixel_valid  output  1  one-cycle pulse qualifying O_pixel
I_vsync  input  1  one-cycle pulse at start of vertical blanking
I_rd_x  input  XW  scan-out column
I_rd_y  input  YW  scan-out row
O_rd_pixel  output  1  front-buffer pixel
O_busy  output  1  high in any state other than IDLE

Behaviour:
Storage and reset
- Storage: back[H][W] and front[H][W], 1 bit per pixel.
- Reset: synchronous, active-high, dominant over every other input in any state, including mid-copy or mid-clear.
- Reset values: both buffers all 0; state IDLE; row counter 0.
- Output reset values: O_cmd_ready=1, O_pixel=0, O_pixel_valid=0, O_rd_pixel=0, O_busy=0.

Command handshake
- A command is accepted when I_cmd_valid && O_cmd_ready.
- O_cmd_ready = 1 only in IDLE.

Per-command effects (in IDLE)
- DRAW: back[y][x] <= 1; the new value is visible to a LOAD in the following cycle.
- CLEAR: back[y][x] <= 0.
- LOAD: O_pixel <= back[y][x] and O_pixel_valid <= 1 on the next cycle.
  - O_pixel_valid is 0 in all other cycles.
  - O_pixel holds its value until the next LOAD.
- Out-of-range coordinates (x >= W or y >= H): DRAW and CLEAR have no effect; LOAD returns 0 with valid asserted.
- PUSH: go to WAIT_VS if PUSH_ON_VSYNC=1, else go to COPY. Row counter <= 0.
- CLRSCR: go to CLEAR, row counter <= 0.

State machine (IDLE, WAIT_VS, COPY, CLEAR)
- WAIT_VS: waits for I_vsync = 1, then enters COPY. A vsync in the same cycle PUSH is accepted does not count; the copy waits for the next pulse.
- COPY: front[row] <= back[row]; row increments each cycle. After row H-1 the state returns to IDLE. Duration is exactly H cycles; O_cmd_ready rises on the cycle after the last row is written.
- CLEAR: back[row] <= 0 for each row, H cycles, then IDLE. The front buffer is untouched.
- I_vsync is ignored in IDLE, COPY and CLEAR.
- Commands presented while not ready are not accepted and not lost: the source holds them until ready.
- Row counter wraps only by returning to IDLE. It never exceeds H-1.

Scan-out read port
- O_rd_pixel <= front[I_rd_y][I_rd_x] every cycle, in every state; latency 1 cycle.
- Out-of-range read address returns 0.
- During COPY, rows already copied return new data and the rest return old data. This is acceptable because H cycles fit inside blanking.

Bus widths
- Coordinate inputs are zero-extended for comparison against W and H.
- No arithmetic wider than YW+1 bits.

Test Plan:
- Reset then LOAD (3,4) -> O_pixel_valid pulses 1 cycle later, O_pixel=0; O_rd_pixel=0 for all addresses.
- DRAW (3,4) then LOAD (3,4) on back-to-back cycles -> O_pixel=1. Read port at (3,4) still 0, since the front buffer is not yet updated.
- DRAW (31,31), PUSH, hold I_vsync low 100 cycles -> O_busy=1 and O_cmd_ready=0 throughout, front unchanged. Pulse I_vsync -> after exactly 32 cycles O_cmd_ready=1 and read port (31,31) gives 1 one cycle after the address is applied.
- PUSH accepted in the same cycle as an I_vsync pulse -> stays in WAIT_VS; copy starts only on the following vsync.
- CLRSCR after drawing (0,0) and (31,0) -> ready low for 32 cycles; then LOAD of both returns 0 while the front buffer still shows 1 until the next PUSH.
- W=20, H=10, PUSH_ON_VSYNC=0: DRAW (25,3) is ignored and LOAD (25,3)=0. PUSH completes in 10 cycles without vsync. Assert I_rst at copy row 5 -> next cycle both buffers all 0, IDLE, ready=1.
